// File: rtl/uart_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_pkg                                                  |
// | Description : Shared types and constants for the UART transmit engine:    |
// |               FSM state encoding, a parity-mode enum for bench/proxy use, |
// |               and frame size limits.                                      |
// | Ports       : none (package)                                              |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
package uart_tx_pkg;

  // Serializer FSM states, explicitly 3 bits wide.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  // Parity mode as seen by software models; the RTL itself uses the two
  // separate enable/odd configuration bits.
  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } uart_parity_e;

  // Largest supported frame: start + 9 data + parity + 2 stop.
  localparam int MAX_DATA_WIDTH = 9;
  localparam int MAX_FRAME_BITS = 1 + MAX_DATA_WIDTH + 1 + 2;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_fifo                                                 |
// | Description : Show-ahead synchronous FIFO buffering words for the UART    |
// |               transmitter. Push and pop on the same edge are legal, even  |
// |               when full; the count is then unchanged.                     |
// | Ports       : clk, rst_n (sync, active-low)                               |
// |               push/push_data  - write strobe and word                     |
// |               pop/pop_data    - read strobe, pop_data is the head word    |
// |               full/empty/count - occupancy status                         |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_r;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count_r == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_r == '0);
  assign count    = count_r;
  assign pop_data = mem[rd_ptr];

  // A push while full is only accepted when a pop frees the head slot on
  // the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers are PTR_W bits wide, so wrap modulo the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage needs no reset; contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_serializer                                           |
// | Description : UART transmit engine. Buffers parallel words from a         |
// |               valid/ready handshake and serialises each one LSB first     |
// |               with a runtime baud divider, optional parity and 1/2 stops. |
// | Ports       : clk, rst_n (sync, active-low)                               |
// |               tx_data/tx_valid/tx_ready - word input handshake            |
// |               baud_div       - clock cycles per bit (0 acts as 1)         |
// |               cfg_parity_en/cfg_parity_odd/cfg_stop2 - frame format       |
// |               tx             - serial line, idle high                     |
// |               busy           - frame in progress or words buffered        |
// |               fifo_count     - words buffered                             |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_odd,
  input  logic                          cfg_stop2,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  uart_tx_state_e        state;
  uart_tx_state_e        next_state;

  logic                  ready_en;
  logic                  push;
  logic                  load;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;

  // Per-frame copies of the configuration, captured when a word is loaded so
  // that configuration changes mid-frame only affect the next frame.
  logic [DIV_WIDTH-1:0]  div_r;
  logic                  par_en_r;
  logic                  parity_bit_r;
  logic                  stop2_r;

  logic [DATA_WIDTH-1:0] shift_r;
  logic [DIV_WIDTH-1:0]  baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DIV_WIDTH-1:0]  div_eff;
  logic                  tick;
  logic                  last_data;
  logic                  last_stop;

  // ready_en keeps tx_ready low throughout reset and for the reset edge
  // itself; it rises on the first edge with rst_n released.
  always_ff @(posedge clk) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  assign tx_ready = ready_en && !fifo_full;
  assign push     = tx_valid && tx_ready;

  uart_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (tx_data),
    .pop       (load),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign div_eff   = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
  assign tick      = (baud_cnt == div_r - DIV_WIDTH'(1));
  assign last_data = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
  assign last_stop = (bit_cnt == BIT_W'(stop2_r));

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // ---------------------------------------------------------------- next state
  // load pops the FIFO head into the shifter; it fires from IDLE or on the
  // final stop tick so back-to-back frames have no idle gap.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          load       = 1'b1;
          next_state = START;
        end
      end
      START: begin
        if (tick) next_state = DATA;
      end
      DATA: begin
        if (tick && last_data) next_state = par_en_r ? PARITY : STOP;
      end
      PARITY: begin
        if (tick) next_state = STOP;
      end
      STOP: begin
        if (tick && last_stop) begin
          if (!fifo_empty) begin
            load       = 1'b1;
            next_state = START;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift_r[0];
      PARITY:  tx = parity_bit_r;
      default: tx = 1'b1;
    endcase
  end

  assign busy = (state != IDLE) || (fifo_count != '0);

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift_r      <= '0;
      div_r        <= DIV_WIDTH'(1);
      par_en_r     <= 1'b0;
      parity_bit_r <= 1'b0;
      stop2_r      <= 1'b0;
    end else begin
      if (load) begin
        shift_r      <= fifo_data;
        div_r        <= div_eff;
        par_en_r     <= cfg_parity_en;
        parity_bit_r <= (^fifo_data) ^ cfg_parity_odd;
        stop2_r      <= cfg_stop2;
      end else if (state == DATA && tick) begin
        shift_r <= {1'b0, shift_r[DATA_WIDTH-1:1]};
      end

      // Both counters restart on every state entry; bit_cnt counts bit
      // periods spent inside DATA and STOP.
      if (next_state != state) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (state != IDLE) begin
        if (tick) begin
          baud_cnt <= '0;
          bit_cnt  <= bit_cnt + 1'b1;
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_serializer                                        |
// | Description : Self-checking bench for uart_tx_serializer. A frame-level   |
// |               model predicts tx/busy/fifo_count/tx_ready every cycle;     |
// |               directed tests add hand-computed literal expectations.      |
// | Ports       : none                                                        |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module tb_uart_tx_serializer;
  import uart_tx_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int DIVW  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [DIVW-1:0] baud_div;
  logic            cfg_parity_en;
  logic            cfg_parity_odd;
  logic            cfg_stop2;
  logic            tx;
  logic            busy;
  logic [2:0]      fifo_count;

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .DIV_WIDTH  (DIVW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .baud_div       (baud_div),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_stop2      (cfg_stop2),
    .tx             (tx),
    .busy           (busy),
    .fifo_count     (fifo_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------ model
  // A frame is a list of line levels, each held for f_div cycles; f_pos is
  // the cycle offset inside the frame currently on the line.
  logic [DW-1:0] mq[$];
  bit            f_active = 1'b0;
  int            f_pos = 0;
  int            f_len = 0;
  int            f_div = 1;
  bit            f_bits[MAX_FRAME_BITS];
  bit            m_ready_en = 1'b0;
  bit            m_accept = 1'b0;
  logic          m_tx = 1'b1;
  logic          m_busy = 1'b0;
  logic          m_ready = 1'b0;
  int            m_count = 0;

  function automatic void start_frame(input logic [DW-1:0] d);
    int n;
    f_div = (baud_div == 0) ? 1 : int'(baud_div);
    f_bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) f_bits[1+i] = d[i];
    n = 1 + DW;
    if (cfg_parity_en) begin
      f_bits[n] = (^d) ^ cfg_parity_odd;
      n++;
    end
    f_bits[n] = 1'b1;
    n++;
    if (cfg_stop2) begin
      f_bits[n] = 1'b1;
      n++;
    end
    f_len    = n * f_div;
    f_pos    = 0;
    f_active = 1'b1;
  endfunction

  always @(posedge clk) begin : model
    bit pre_ready;
    m_accept = 1'b0;
    if (rst_n !== 1'b1) begin
      mq.delete();
      f_active   = 1'b0;
      m_ready_en = 1'b0;
    end else begin
      pre_ready = m_ready_en && (mq.size() != DEPTH);
      if (f_active) begin
        f_pos++;
        if (f_pos >= f_len) f_active = 1'b0;
      end
      if (!f_active && mq.size() != 0) start_frame(mq.pop_front());
      if (tx_valid && pre_ready) begin
        mq.push_back(tx_data);
        m_accept = 1'b1;
      end
      m_ready_en = 1'b1;
    end
    m_tx    = f_active ? f_bits[f_pos / f_div] : 1'b1;
    m_busy  = f_active || (mq.size() != 0);
    m_count = mq.size();
    m_ready = m_ready_en && (mq.size() != DEPTH);
  end

  // ------------------------------------------------------------------ compare
  bit chk_en = 1'b0;
  int max_cnt = 0;
  bit saw_not_ready = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx", tx, m_tx);
      chk("busy", busy, m_busy);
      chk("fifo_count", fifo_count, m_count);
      chk("tx_ready", tx_ready, m_ready);
      if (!$isunknown(fifo_count) && int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (rst_n === 1'b1 && tx_ready === 1'b0) saw_not_ready = 1'b1;
    end
  end

  // ------------------------------------------------------------------ driver
  task automatic set_cfg(input int div, input uart_parity_e p, input bit s2);
    logic [31:0] d32;
    d32            = div;
    baud_div       = d32[DIVW-1:0];
    cfg_parity_en  = (p != PARITY_NONE);
    cfg_parity_odd = (p == PARITY_ODD);
    cfg_stop2      = s2;
  endtask

  // Holds tx_valid until the word is taken; returns #1 after the accepting
  // edge with tx_valid still high so callers can stream words.
  task automatic push(input logic [DW-1:0] d);
    bit acc;
    acc      = 1'b0;
    tx_valid = 1'b1;
    tx_data  = d;
    for (int t = 0; t < 400 && !acc; t++) begin
      @(posedge clk);
      #1;
      acc = m_accept;
    end
    chk("push_accept", acc, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < budget && !idle; t++) begin
      @(negedge clk);
      idle = (busy === 1'b0);
    end
    chk("idle_reached", idle, 1'b1);
  endtask

  int a5_bits[11]   = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
  int zero_bits[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
  logic [DW-1:0] burst[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  initial begin
    int c;
    int low_cnt;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    set_cfg(4, PARITY_EVEN, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_count", fifo_count, 3'd0);
    chk("reset_ready", tx_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", tx_ready, 1'b1);

    // Single frame 0xA5, div 4, even parity, 1 stop: 44 cycles
    push(8'hA5);
    tx_valid = 1'b0;
    @(posedge clk);
    for (int k = 0; k <= 44; k++) begin
      @(negedge clk);
      if (k < 44 && (k % 4) == 2) chk($sformatf("a5_bit%0d", k / 4), tx, a5_bits[k/4]);
      if (k == 43) chk("a5_busy_last", busy, 1'b1);
      if (k == 44) chk("a5_busy_drop", busy, 1'b0);
    end

    // div 0 (acts as 1), odd parity, 2 stops, 0x00: 12 cycles
    set_cfg(0, PARITY_ODD, 1'b1);
    push(8'h00);
    tx_valid = 1'b0;
    @(posedge clk);
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k < 12) chk($sformatf("zero_bit%0d", k), tx, zero_bits[k]);
      if (k == 11) chk("zero_busy_last", busy, 1'b1);
      if (k == 12) chk("zero_busy_drop", busy, 1'b0);
    end

    // Back-to-back with backpressure, div 2
    set_cfg(2, PARITY_NONE, 1'b0);
    max_cnt = 0;
    saw_not_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(burst[i]);
    tx_valid = 1'b0;
    wait_idle(400);
    chk("burst_max_count", max_cnt, 4);
    chk("burst_backpressure", saw_not_ready, 1'b1);

    // Config change during frame 1 DATA: 3*11 + 5*10 = 83 cycles busy
    set_cfg(3, PARITY_EVEN, 1'b0);
    push(8'h5A);
    push(8'hC3);
    tx_valid = 1'b0;
    c = 0;
    while (c < 300) begin
      @(negedge clk);
      if (c == 10) set_cfg(5, PARITY_NONE, 1'b0);
      if (busy === 1'b0) break;
      c++;
    end
    chk("cfg_total_cycles", c, 83);

    // Reset mid-frame with 3 words queued
    set_cfg(4, PARITY_NONE, 1'b0);
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    tx_valid = 1'b0;
    @(negedge clk);
    chk("queued_before_reset", fifo_count, 3'd3);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_tx", tx, 1'b1);
    chk("midreset_count", fifo_count, 3'd0);
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_ready", tx_ready, 1'b0);
    rst_n = 1'b1;
    low_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) low_cnt++;
    end
    chk("no_frames_after_reset", low_cnt, 0);

    // Full FIFO with pops freeing slots at div 1
    set_cfg(1, PARITY_NONE, 1'b0);
    max_cnt = 0;
    for (int i = 0; i < 6; i++) push(burst[5-i]);
    push(8'hE7);
    tx_valid = 1'b0;
    wait_idle(300);
    chk("full_max_count", max_cnt, 4);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Synthesizable, parametrised UART transmit engine. It is the RTL successor to the device-side driver BFM and becomes the serial source behind the device agent interface.
- Accepts parallel words on a valid/ready handshake.
- Buffers them in an internal FIFO.
- Serialises each word onto a single tx line with a runtime baud divider, optional even/odd parity and 1 or 2 stop bits.
- Also used as the DUT-side transmitter in loopback benches.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9), sent LSB first
FIFO_DEPTH, 4, TX buffer entries (power of 2, >=2)
DIV_WIDTH, 16, width of baud divider input

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
tx_data  input  DATA_WIDTH  word to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  FIFO can accept a word (not full)
baud_div  input  DIV_WIDTH  clock cycles per bit; 0 treated as 1
cfg_parity_en  input  1  append parity bit
cfg_parity_odd  input  1  1 = odd parity, 0 = even
cfg_stop2  input  1  1 = two stop bits, 0 = one
tx  output  1  serial line, idle high
busy  output  1  frame in progress or FIFO non-empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  words buffered

Behaviour:
- Clocking and reset:
  - Single clock domain: clk.
  - rst_n sampled on rising clk only (synchronous, active-low).
  - Reset values: tx=1, busy=0, fifo_count=0, tx_ready=0 while rst_n=0; tx_ready=1 from the first edge after release.
  - FIFO pointers cleared; FSM=IDLE; baud and bit counters=0.
- Handshake:
  - A word is accepted on an edge where tx_valid && tx_ready.
  - tx_ready = (fifo_count != FIFO_DEPTH), registered-count based.
  - tx_data must be held while tx_valid && !tx_ready. No drop, no overflow flag.
- FIFO:
  - Push and pop on the same edge leave the count unchanged and are legal, including at full. Full blocks push via tx_ready.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pop only from IDLE or the final stop-bit tick.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If FIFO non-empty: pop into shift register; latch baud_div, parity config and stop config into frame registers; go to START. Config changes mid-frame have no effect on the current frame.
  - START: tx=0 for one bit period, then DATA.
  - DATA: tx=shift[0]; shift right each bit period. After DATA_WIDTH bits go to PARITY if parity enabled, else STOP.
  - PARITY: tx = XOR of data bits, inverted when odd parity. One bit period, then STOP.
  - STOP: tx=1 for 1 or 2 bit periods.
    - At the final tick, if FIFO non-empty: pop and go directly to START (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- Bit period:
  - Baud counter counts 0..div-1, where div = max(baud_div,1).
  - Bit advances when the counter reaches div-1; the counter reloads at each state entry.
- Latency:
  - Word accepted at edge k with the FSM idle and FIFO empty: pop at edge k+1; tx=0 visible after edge k+1.
  - Frame length = div*(1+DATA_WIDTH+parity_en+1+stop2) cycles.
- busy = (state != IDLE) || (fifo_count != 0).
- Reset mid-frame: tx returns high at the reset edge, buffered words discarded, no partial frame completion.
- div=1: one cycle per bit, back-to-back frames still gapless.

Decomposition:
- Package uart_tx_pkg:
  - typedef enum uart_tx_state_e {IDLE, START, DATA, PARITY, STOP}.
  - Parity enum {PARITY_NONE, PARITY_EVEN, PARITY_ODD} for bench/proxy use.
  - Localparam for max frame bits.
- Sub-module uart_tx_fifo (DATA_WIDTH, FIFO_DEPTH; push/pop/full/empty/count), instantiated once.
- FSM, baud counter and shifter stay in the top.

Test Plan:
- Single frame: DATA_WIDTH=8, baud_div=4, even parity, 1 stop, send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles, 44 cycles total; busy drops the cycle after the stop bit ends.
- Odd parity, 2 stop bits, baud_div=0 (treated as 1), send 0x00 -> frame 0,00000000,1,1,1 at 1 cycle per bit, 12 cycles.
- Back-to-back/backpressure: FIFO_DEPTH=4, push 6 words continuously at baud_div=2 -> tx_ready low after the 4th un-popped push (after 5 accepted, as 1 is popped immediately), 6 frames with no idle gap, data order preserved, fifo_count never exceeds 4.
- Config change mid-frame: toggle cfg_parity_en and baud_div during DATA of frame 1 -> frame 1 unchanged; frame 2 uses the new config.
- Reset mid-frame: assert rst_n=0 during DATA with 3 words queued -> tx=1, fifo_count=0, busy=0, tx_ready=0 after the next edge; after release tx stays high with no further frames.
- Simultaneous push/pop at full: FIFO full and stop-bit final tick coincides with a push -> count stays 4 and the word is stored.
